// File: rtl/vram_arbiter.sv
// Single-port pixel RAM arbiter: VGA scan-out reads win every cycle, buffered CPU
// writes drain in blanking, and CPU reads complete only after the write FIFO is empty.
module vram_arbiter #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          vga_clk,
  input  logic                          clrn,
  input  logic                          vga_rdn,
  input  logic [8:0]                    vga_row,
  input  logic [9:0]                    vga_col,
  output logic [7:0]                    vga_data,
  input  logic                          cpu_wr_valid,
  output logic                          cpu_wr_ready,
  input  logic [18:0]                   cpu_wr_addr,
  input  logic [7:0]                    cpu_wr_data,
  input  logic                          cpu_rd_req,
  input  logic [18:0]                   cpu_rd_addr,
  output logic                          cpu_rd_busy,
  output logic                          cpu_rd_ack,
  output logic [7:0]                    cpu_rd_data,
  output logic [18:0]                   ram_addr,
  output logic                          ram_we,
  output logic [7:0]                    ram_wdata,
  input  logic [7:0]                    ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_VGA, SLOT_WRITE, SLOT_READ} slot_e;
  typedef enum logic {RD_IDLE, RD_WAIT} rd_state_e;

  slot_e       slot;
  rd_state_e   rd_state;
  logic [18:0] rd_addr_q;
  logic [18:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]  fifo_data [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic        push, pop;

  assign vga_data     = ram_rdata;
  assign cpu_rd_busy  = (rd_state == RD_WAIT);
  assign cpu_wr_ready = (fifo_count < FULL_COUNT) && !cpu_rd_busy;
  assign push         = cpu_wr_valid && cpu_wr_ready;
  assign pop          = (slot == SLOT_WRITE);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    slot = SLOT_IDLE;
    if (!vga_rdn)                slot = SLOT_VGA;
    else if (fifo_count != '0)   slot = SLOT_WRITE;
    else if (rd_state == RD_WAIT) slot = SLOT_READ;
  end

  always_comb begin
    ram_addr  = {vga_row, vga_col};
    ram_we    = 1'b0;
    ram_wdata = fifo_data[rd_ptr];
    case (slot)
      SLOT_WRITE: begin
        ram_addr = fifo_addr[rd_ptr];
        ram_we   = 1'b1;
      end
      SLOT_READ: ram_addr = rd_addr_q;
      default: ;
    endcase
  end

  // NOTE: the FIFO storage has no reset; only pointers and count need one, which keeps it RAM-friendly.
  always_ff @(posedge vga_clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cpu_wr_addr;
      fifo_data[wr_ptr] <= cpu_wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  // A pending read holds off new writes, so the FIFO empties and the read slot is reached.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      rd_state    <= RD_IDLE;
      rd_addr_q   <= '0;
      cpu_rd_ack  <= 1'b0;
      cpu_rd_data <= '0;
    end else begin
      cpu_rd_ack <= 1'b0;
      case (rd_state)
        RD_IDLE: begin
          if (cpu_rd_req) begin
            rd_addr_q <= cpu_rd_addr;
            rd_state  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (slot == SLOT_READ) begin
            cpu_rd_data <= ram_rdata;
            cpu_rd_ack  <= 1'b1;
            rd_state    <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a queue-based model of the arbitration rules predicts every
// output each cycle, while directed phases and random traffic exercise the corner cases.
module tb_vram_arbiter;

  logic        vga_clk = 1'b0;
  logic        clrn;
  logic        vga_rdn;
  logic [8:0]  vga_row;
  logic [9:0]  vga_col;
  logic [7:0]  vga_data;
  logic        cpu_wr_valid;
  logic        cpu_wr_ready;
  logic [18:0] cpu_wr_addr;
  logic [7:0]  cpu_wr_data;
  logic        cpu_rd_req;
  logic [18:0] cpu_rd_addr;
  logic        cpu_rd_busy;
  logic        cpu_rd_ack;
  logic [7:0]  cpu_rd_data;
  logic [18:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [3:0]  fifo_count;

  vram_arbiter #(.FIFO_DEPTH(8)) dut (
    .vga_clk(vga_clk), .clrn(clrn), .vga_rdn(vga_rdn), .vga_row(vga_row), .vga_col(vga_col),
    .vga_data(vga_data), .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
    .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data), .cpu_rd_req(cpu_rd_req),
    .cpu_rd_addr(cpu_rd_addr), .cpu_rd_busy(cpu_rd_busy), .cpu_rd_ack(cpu_rd_ack),
    .cpu_rd_data(cpu_rd_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .fifo_count(fifo_count)
  );

  always #20 vga_clk = ~vga_clk;

  // Pixel RAM: combinational read, write on the clock edge.
  logic [7:0] vram [0:(1<<19)-1];
  assign ram_rdata = vram[ram_addr];
  always @(posedge vga_clk) if (ram_we) vram[ram_addr] <= ram_wdata;

  // Reference model state.
  typedef struct { logic [18:0] addr; logic [7:0] data; } wr_t;
  wr_t         wq[$];
  bit          m_busy;
  logic [18:0] m_addr;
  bit          m_ack;
  logic [7:0]  m_data;

  int n_checks = 0;
  int n_fail   = 0;
  int we_seen  = 0;
  int acks_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    m_busy = 0;
    m_addr = '0;
    m_ack  = 0;
    m_data = '0;
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model, return just after the edge.
  task automatic step();
    logic [18:0] e_addr;
    bit          e_we, e_ready, is_read;
    logic [7:0]  e_wdata;
    @(negedge vga_clk);
    e_ready = (wq.size() < 8) && !m_busy;
    e_we = 0; e_wdata = '0; is_read = 0;
    e_addr = {vga_row, vga_col};
    if (vga_rdn) begin
      if (wq.size() > 0) begin
        e_addr = wq[0].addr; e_we = 1; e_wdata = wq[0].data;
      end else if (m_busy) begin
        e_addr = m_addr; is_read = 1;
      end
    end
    check("fifo_count", 32'(fifo_count), 32'(wq.size()));
    check("wr_ready", 32'(cpu_wr_ready), 32'(e_ready));
    check("rd_busy", 32'(cpu_rd_busy), 32'(m_busy));
    check("rd_ack", 32'(cpu_rd_ack), 32'(m_ack));
    check("rd_data", 32'(cpu_rd_data), 32'(m_data));
    check("ram_we", 32'(ram_we), 32'(e_we));
    check("ram_addr", 32'(ram_addr), 32'(e_addr));
    if (e_we) check("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
    check("vga_data", 32'(vga_data), 32'(vram[e_addr]));
    if (ram_we) we_seen++;
    if (cpu_rd_ack) acks_seen++;
    if (clrn) begin
      m_ack = 0;
      if (is_read) begin
        m_ack = 1; m_data = vram[e_addr]; m_busy = 0;
      end else if (!m_busy && cpu_rd_req) begin
        m_busy = 1; m_addr = cpu_rd_addr;
      end
      if (e_we) void'(wq.pop_front());
      if (cpu_wr_valid && e_ready) wq.push_back('{addr: cpu_wr_addr, data: cpu_wr_data});
    end
    @(posedge vga_clk);
    #1;
    vga_col = (vga_col == 10'd799) ? 10'd0 : vga_col + 1'b1;
  endtask

  task automatic idle_inputs();
    cpu_wr_valid = 0;
    cpu_rd_req   = 0;
  endtask

  logic [18:0] blk_addr;
  logic [7:0]  blk_exp;

  initial begin
    for (int i = 0; i < (1<<19); i++) vram[i] = 8'(i) ^ 8'h5A;
    clrn = 0; vga_rdn = 1; vga_row = 9'd3; vga_col = '0;
    cpu_wr_addr = '0; cpu_wr_data = '0; cpu_rd_addr = '0;
    idle_inputs();
    model_reset();

    // Reset with random inputs.
    for (int i = 0; i < 6; i++) begin
      vga_rdn = 1'($urandom); cpu_wr_valid = 1'($urandom); cpu_rd_req = 1'($urandom);
      cpu_wr_addr = 19'($urandom); cpu_rd_addr = 19'($urandom); cpu_wr_data = 8'($urandom);
      step();
    end
    idle_inputs(); vga_rdn = 1;
    clrn = 1;
    acks_seen = 0;
    for (int i = 0; i < 4; i++) step();
    check("no_spurious_ack", 32'(acks_seen), 32'd0);

    // VGA priority: scan-out for 640 cycles while 8 writes fill the FIFO.
    vga_rdn = 0; we_seen = 0;
    for (int i = 0; i < 640; i++) begin
      cpu_wr_valid = (i < 9);
      cpu_wr_addr  = 19'h10000 + 19'(i);
      cpu_wr_data  = 8'(8'hA0 + i);
      if (i == 8) check("push9_refused", 32'(cpu_wr_ready), 32'd0);
      step();
    end
    cpu_wr_valid = 0;
    check("scan_no_we", 32'(we_seen), 32'd0);
    check("full_count", 32'(fifo_count), 32'd8);
    vga_rdn = 1;
    for (int i = 0; i < 12; i++) step();
    check("drain_we_cycles", 32'(we_seen), 32'd8);
    check("drained_value", 32'(vram[19'h10007]), 32'hA7);

    // Simultaneous push and pop at occupancy 3.
    vga_rdn = 0;
    for (int i = 0; i < 3; i++) begin
      cpu_wr_valid = 1; cpu_wr_addr = 19'h20000 + 19'(i); cpu_wr_data = 8'(i); step();
    end
    vga_rdn = 1;
    for (int i = 3; i < 13; i++) begin
      cpu_wr_addr = 19'h20000 + 19'(i); cpu_wr_data = 8'(i); step();
      check("pushpop_count", 32'(fifo_count), 32'd3);
    end
    idle_inputs();
    for (int i = 0; i < 5; i++) step();

    // Read-after-write during blanking.
    cpu_wr_valid = 1; cpu_wr_addr = 19'h00A05; cpu_wr_data = 8'h1F; step();
    cpu_wr_valid = 0; cpu_rd_req = 1; cpu_rd_addr = 19'h00A05; acks_seen = 0; step();
    cpu_rd_req = 0;
    check("raw_busy_blocks_wr", 32'(cpu_wr_ready), 32'd0);
    for (int i = 0; i < 4; i++) step();
    check("raw_ack_once", 32'(acks_seen), 32'd1);
    check("raw_data", 32'(cpu_rd_data), 32'h1F);

    // Read blocked by scan-out; a second request while busy is ignored.
    blk_addr = 19'h3_1234; blk_exp = vram[blk_addr];
    vga_rdn = 0; cpu_rd_req = 1; cpu_rd_addr = blk_addr; acks_seen = 0; step();
    cpu_rd_addr = 19'h0_0777;
    for (int i = 0; i < 6; i++) step();
    check("blocked_no_ack", 32'(acks_seen), 32'd0);
    cpu_rd_req = 0; vga_rdn = 1;
    step();
    step();
    check("blocked_ack", 32'(acks_seen), 32'd1);
    check("blocked_data", 32'(cpu_rd_data), 32'(blk_exp));

    // Reset mid-operation: 5 buffered writes plus a pending read.
    vga_rdn = 0;
    for (int i = 0; i < 5; i++) begin
      cpu_wr_valid = 1; cpu_wr_addr = 19'h40000 + 19'(i); cpu_wr_data = 8'hEE; step();
    end
    cpu_wr_valid = 0; cpu_rd_req = 1; cpu_rd_addr = 19'h40000; step();
    cpu_rd_req = 0;
    check("pre_reset_count", 32'(fifo_count), 32'd5);
    clrn = 0; model_reset(); #1;
    check("async_count", 32'(fifo_count), 32'd0);
    check("async_busy", 32'(cpu_rd_busy), 32'd0);
    step();
    clrn = 1; vga_rdn = 1; we_seen = 0; acks_seen = 0;
    for (int i = 0; i < 10; i++) step();
    check("flush_no_we", 32'(we_seen), 32'd0);
    check("flush_no_ack", 32'(acks_seen), 32'd0);

    // Random traffic in a small address window so reads often hit buffered writes.
    for (int i = 0; i < 3000; i++) begin
      vga_rdn      = ($urandom_range(0, 3) == 0);
      vga_row      = 9'($urandom_range(0, 479));
      cpu_wr_valid = 1'($urandom);
      cpu_wr_addr  = 19'h00A00 + 19'($urandom_range(0, 15));
      cpu_wr_data  = 8'($urandom);
      cpu_rd_req   = ($urandom_range(0, 3) == 0);
      cpu_rd_addr  = 19'h00A00 + 19'($urandom_range(0, 15));
      step();
    end
    idle_inputs(); vga_rdn = 1;
    for (int i = 0; i < 20; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port pixel RAM between the VGA scan-out controller and the CPU. VGA scan-out reads always win. CPU writes are buffered in a small FIFO and drained in cycles where the VGA side is not reading (blanking intervals). CPU reads are serviced after the FIFO drains, so read-after-write ordering holds. It sits between the VGA controller, the CPU bus glue and the pixel RAM, all clocked by the 25 MHz pixel clock.

## Interface
- FIFO_DEPTH, 8: CPU write buffer entries; power of two, 2..64
- vga_clk  in  1  pixel clock (25 MHz); the only clock
- clrn  in  1  reset, asynchronous, active-low
- vga_rdn  in  1  VGA read request, active low; VGA owns the RAM that cycle when 0
- vga_row  in  9  VGA pixel row address
- vga_col  in  10  VGA pixel column address
- vga_data  out  8  pixel to VGA controller; equals ram_rdata (combinational)
- cpu_wr_valid  in  1  CPU write request
- cpu_wr_ready  out  1  write accepted this cycle when valid&ready
- cpu_wr_addr  in  19  {row[8:0], col[9:0]}
- cpu_wr_data  in  8  rrr_ggg_bb pixel
- cpu_rd_req  in  1  CPU read request; sampled only when cpu_rd_busy=0
- cpu_rd_addr  in  19  {row, col}
- cpu_rd_busy  out  1  read accepted, not yet acknowledged
- cpu_rd_ack  out  1  one-cycle pulse; cpu_rd_data valid in the same cycle
- cpu_rd_data  out  8  read pixel, held until the next ack
- ram_addr  out  19  RAM address {row, col}
- ram_we  out  1  RAM write enable
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data; combinational (same-cycle) read
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Slot decision is made every cycle, with priority in this order:
  1. VGA: vga_rdn=0. ram_addr={vga_row,vga_col}, ram_we=0.
  2. WRITE: FIFO not empty. Pop the head: ram_addr=head.addr, ram_wdata=head.data, ram_we=1.
  3. READ: cpu_rd_busy=1 and FIFO empty. ram_addr=captured read address, ram_we=0. ram_rdata is registered into cpu_rd_data.
  4. IDLE: ram_addr={vga_row,vga_col}, ram_we=0.
- Slot selection and ram_* outputs are combinational. The FIFO, read state and cpu_rd_* outputs are registered.
- Write FIFO behaviour:
  - cpu_wr_ready = (fifo_count < FIFO_DEPTH) & ~cpu_rd_busy.
  - Push on cpu_wr_valid & cpu_wr_ready; pop in a WRITE slot.
  - Push and pop in the same cycle: fifo_count unchanged.
  - A push into an empty FIFO is not visible to the slot logic until the next cycle. There is no bypass.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Read state machine:
  - RD_IDLE → RD_WAIT when cpu_rd_req=1. cpu_rd_addr is captured and cpu_rd_busy=1 from the next cycle.
  - RD_WAIT → RD_IDLE on the first READ slot.
  - cpu_rd_req is ignored while busy.
- Ordering: reads never bypass buffered writes. Writes are blocked while a read is pending, which guarantees the read completes once blanking occurs.
- Out-of-range CPU addresses (col ≥ 640, row ≥ 480) are written or read unchanged. RAM aliasing is not this block's concern.

## Timing
- Reset values (clrn=0, asynchronous):
  - fifo_count=0, pointers=0, read state RD_IDLE.
  - cpu_rd_busy=0, cpu_rd_ack=0, cpu_rd_data=0.
  - cpu_wr_ready=1 (derived).
  - ram_we=0 while in reset.
- Reset mid-operation flushes the FIFO (buffered writes are lost) and drops the pending read with no ack.
- Write latency: a write accepted at edge N reaches RAM no earlier than cycle N+1. Worst case it waits for the next cycle with vga_rdn=1.
- Read latency:
  - Request sampled at edge N; busy from N.
  - Given an empty FIFO and vga_rdn=1 in cycle N+1, the READ slot occurs in cycle N+1.
  - At edge N+2: cpu_rd_ack=1 and cpu_rd_data valid; busy=0.
  - Minimum 2 cycles from request to ack.
- VGA path has zero added latency. vga_data follows ram_rdata in the same cycle the VGA controller presents its address.
- Throughput: one RAM access per cycle. A full FIFO of 8 drains in 8 blanking cycles; horizontal blanking is 160 cycles per line.

## Test plan
- Reset state: hold clrn=0 with random inputs → cpu_wr_ready=1, fifo_count=0, cpu_rd_busy=0, cpu_rd_ack=0, ram_we=0. Release and check no spurious ack.
- VGA priority: vga_rdn=0 for 640 cycles while the CPU pushes 8 writes → push 9 is refused (ready=0), ram_we stays 0, ram_addr tracks {vga_row,vga_col}. Raise vga_rdn=1 → exactly 8 consecutive ram_we=1 cycles, writes in push order, fifo_count falls 8→0.
- Simultaneous push/pop: with fifo_count=3 in blanking, push every cycle → count stays 3, addresses pop in FIFO order.
- Read-after-write: write 0x1F to addr 0x00A05, then immediately read 0x00A05 during blanking → write slot precedes read slot; cpu_rd_ack pulses once with cpu_rd_data=0x1F; cpu_wr_ready=0 while busy.
- Read blocked by scan-out: issue a read with vga_rdn=0 → busy held, no ack. ack arrives 1 cycle after the first vga_rdn=1 cycle; a second cpu_rd_req during busy is ignored.
- Reset mid-operation: with fifo_count=5 and a read pending, pulse clrn low for 1 cycle → count=0, busy=0, no ack, no further ram_we=1.
